// File: rtl/data_bus_responder.sv
// data_bus_responder: single-port RAM responder with a memory-mapped LED register.
// A request is captured in IDLE, stalled WAIT_STATES cycles, then answered with a one-cycle ready
// strobe. RAM and LED writes, and load data, all take effect on the edge that enters RESP.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit RAM words (power of 2)
//   WAIT_STATES  stall cycles between capture and response (0..15)
//   LED_ADDR     byte address of the LED register
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   mem_read       load request (sampled in IDLE)
//   mem_write      store request (sampled in IDLE)
//   mem            funct3 size/sign code
//   addr           byte address
//   write_data     store data, low lanes
//   read_data      load result, zero unless a successful load is responding
//   ready          one-cycle response strobe
//   err            error flag, valid with ready
//   led_indicator  bit 0 of the LED register
module data_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err,
  output logic        led_indicator
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  mem_q;
  logic        write_q;
  logic        dual_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  led_q;

  logic [31:0] ram [DEPTH_WORDS];

  // In IDLE the live inputs are decoded so a zero-wait request can respond on its capture edge.
  logic        is_idle;
  logic        accept;
  logic        go_resp;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_mem;
  logic        cur_write;
  logic        cur_dual;

  assign is_idle   = (state_q == StIdle);
  assign accept    = is_idle & (mem_read | mem_write);
  assign cur_addr  = is_idle ? addr : addr_q;
  assign cur_wdata = is_idle ? write_data : wdata_q;
  assign cur_mem   = is_idle ? mem : mem_q;
  assign cur_write = is_idle ? (mem_write & ~mem_read) : write_q;
  assign cur_dual  = is_idle ? (mem_read & mem_write) : dual_q;

  always_comb begin
    go_resp = 1'b0;
    if (accept && (WAIT_STATES == 0)) go_resp = 1'b1;
    if (state_q == StWait && cnt_q == 4'd0) go_resp = 1'b1;
  end

  // Address and code decode
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic            is_led;
  logic            code_bad;
  logic            misalign;
  logic            acc_err;

  assign idx      = cur_addr[IdxW+1:2];
  assign in_range = (cur_addr >> (IdxW + 2)) == 32'd0;
  assign is_led   = (cur_addr == LED_ADDR);

  always_comb begin
    code_bad = 1'b0;
    misalign = 1'b0;
    case (cur_mem)
      3'b000:  misalign = 1'b0;
      3'b001:  misalign = cur_addr[0];
      3'b010:  misalign = |cur_addr[1:0];
      3'b100:  code_bad = cur_write;
      3'b101: begin
        code_bad = cur_write;
        misalign = cur_addr[0];
      end
      default: code_bad = 1'b1;
    endcase
  end

  assign acc_err = code_bad | misalign | cur_dual | (~is_led & ~in_range);

  // Load path
  logic [31:0] word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign word = ram[idx];

  always_comb begin
    case (cur_addr[1:0])
      2'd0:    ld_byte = word[7:0];
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    ld_half = cur_addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (cur_mem)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'h0, ld_byte};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = word;
    endcase
    if (is_led) load_val = {24'h0, led_q};
  end

  // Store path: data is replicated across lanes so the byte enables alone pick the target.
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        ram_we;
  logic        led_we;

  always_comb begin
    case (cur_mem)
      3'b000: begin
        be    = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = cur_wdata;
      end
    endcase
  end

  assign ram_we = go_resp & cur_write & ~acc_err & ~is_led;
  assign led_we = go_resp & cur_write & ~acc_err & is_led;

  // RAM has no reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_q   <= '0;
      write_q <= 1'b0;
      dual_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= addr;
            wdata_q <= write_data;
            mem_q   <= mem;
            write_q <= mem_write & ~mem_read;
            dual_q  <= mem_read & mem_write;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= acc_err;
        if (!cur_write && !acc_err) rdata_q <= load_val;
        if (led_we) led_q <= cur_wdata[7:0];
      end
    end
  end

  assign read_data     = rdata_q;
  assign ready         = ready_q;
  assign err           = err_q;
  assign led_indicator = led_q[0];

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios plus randomized traffic checked against a
// byte-addressed reference model. Instance u_dut1 uses one wait state, u_dut0 uses none.
module tb_data_bus_responder;

  localparam int unsigned Depth   = 256;
  localparam logic [31:0] LedAddr = 32'hFFFF_FF00;

  logic        clk;
  logic        reset;
  logic        rd1, wr1, rd0, wr0;
  logic [2:0]  mem;
  logic [31:0] addr, wdata;
  logic [31:0] rdata1, rdata0;
  logic        ready1, ready0, err1, err0, led1, led0;

  int checks;
  int errors;

  // Reference model state
  logic [7:0] mb [4*Depth];
  logic [7:0] led_m;

  // Results of the last access
  int          lat;
  logic        e_o;
  logic [31:0] r_o;
  logic        rdy_a;
  logic [31:0] r_a;
  bit          exp_e;
  logic [31:0] exp_r;

  data_bus_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(1), .LED_ADDR(LedAddr)) u_dut1 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .mem(mem), .addr(addr),
    .write_data(wdata), .read_data(rdata1), .ready(ready1), .err(err1), .led_indicator(led1)
  );

  data_bus_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(0), .LED_ADDR(LedAddr)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .mem(mem), .addr(addr),
    .write_data(wdata), .read_data(rdata0), .ready(ready0), .err(err0), .led_indicator(led0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model: memory as little-endian bytes; result computed from size/sign/alignment rules.
  task automatic model_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output bit e, output logic [31:0] r);
    int sz;
    bit led_hit;
    logic [31:0] v;
    e = 1'b0;
    r = '0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    led_hit = (a == LedAddr);
    if (rd && wr) e = 1'b1;
    if (sz == 0) e = 1'b1;
    else if ((a % sz) != 0) e = 1'b1;
    if (wr && f3[2]) e = 1'b1;
    if (!led_hit && a >= 4 * Depth) e = 1'b1;
    if (e) return;
    if (wr) begin
      if (led_hit) led_m = wd[7:0];
      else for (int i = 0; i < sz; i++) mb[10'(a + 32'(i))] = wd[8*i +: 8];
    end else if (led_hit) begin
      r = {24'h0, led_m};
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[10'(a + 32'(i))]) << (8 * i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      r = v;
    end
  endtask

  // Issue one request to the selected instance; returns one edge after the ready strobe.
  task automatic access(input bit sel, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    if (sel) model_op(rd, wr, f3, a, wd, exp_e, exp_r);
    else begin
      exp_e = 1'b0;
      exp_r = '0;
    end
    mem   = f3;
    addr  = a;
    wdata = wd;
    if (sel) begin
      rd1 = rd;
      wr1 = wr;
    end else begin
      rd0 = rd;
      wr0 = wr;
    end
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      rd1 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
      lat++;
    end while (!(sel ? ready1 : ready0) && lat < 40);
    e_o = sel ? err1 : err0;
    r_o = sel ? rdata1 : rdata0;
    @(posedge clk);
    #1;
    rdy_a = sel ? ready1 : ready0;
    r_a   = sel ? rdata1 : rdata0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    mem = '0; addr = '0; wdata = '0;
    #12;
    checks++;
    if ({ready1, err1, led1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {ready1, err1, led1});
    end
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 00000000", rdata1);
    end
    @(negedge clk);
    reset = 1'b1;
    // First request straight after release must be taken on the next edge.
    access(1, 0, 1, 3'd2, 32'h0, $urandom);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL first_req_lat got %0d exp 2", lat);
    end
  endtask

  task automatic test_fill();
    for (int w = 1; w < 16; w++) begin
      access(1, 0, 1, 3'd2, 32'(w * 4), $urandom);
      checks++;
      if (e_o !== 1'b0 || lat !== 2) begin
        errors++;
        $display("FAIL fill_%0d got err=%b lat=%0d exp err=0 lat=2", w, e_o, lat);
      end
    end
  endtask

  task automatic test_sw_lw();
    access(1, 0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (lat !== 2 || e_o !== 1'b0 || r_o !== 32'h0) begin
      errors++;
      $display("FAIL sw_resp got lat=%0d err=%b rd=%h exp lat=2 err=0 rd=0", lat, e_o, r_o);
    end
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL sw_strobe got ready=%b exp 0", rdy_a);
    end
    access(1, 1, 0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (lat !== 2 || e_o !== 1'b0 || r_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_resp got lat=%0d err=%b rd=%h exp lat=2 err=0 rd=deadbeef", lat, e_o, r_o);
    end
    checks++;
    if (rdy_a !== 1'b0 || r_a !== 32'h0) begin
      errors++;
      $display("FAIL lw_after got ready=%b rd=%h exp ready=0 rd=0", rdy_a, r_a);
    end
  endtask

  task automatic test_bytes();
    access(1, 0, 1, 3'd0, 32'h11, 32'h0000_007F);
    access(1, 1, 0, 3'd0, 32'h11, 32'h0);
    checks++;
    if (r_o !== 32'h0000_007F) begin
      errors++;
      $display("FAIL lb_pos got %h exp 0000007f", r_o);
    end
    access(1, 0, 1, 3'd0, 32'h11, 32'h0000_0080);
    access(1, 1, 0, 3'd0, 32'h11, 32'h0);
    checks++;
    if (r_o !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_neg got %h exp ffffff80", r_o);
    end
    access(1, 1, 0, 3'd4, 32'h11, 32'h0);
    checks++;
    if (r_o !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu got %h exp 00000080", r_o);
    end
    access(1, 1, 0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (r_o !== 32'hDEAD_80EF) begin
      errors++;
      $display("FAIL lw_merge got %h exp dead80ef", r_o);
    end
  endtask

  task automatic test_errors();
    access(1, 1, 0, 3'd2, 32'h12, 32'h0);
    checks++;
    if (e_o !== 1'b1 || r_o !== 32'h0) begin
      errors++;
      $display("FAIL lw_misalign got err=%b rd=%h exp err=1 rd=0", e_o, r_o);
    end
    access(1, 0, 1, 3'd1, 32'h13, 32'h0000_1234);
    checks++;
    if (e_o !== 1'b1) begin
      errors++;
      $display("FAIL sh_misalign got err=%b exp 1", e_o);
    end
    access(1, 1, 1, 3'd2, 32'h10, 32'h5555_5555);
    checks++;
    if (e_o !== 1'b1 || r_o !== 32'h0) begin
      errors++;
      $display("FAIL dual_req got err=%b rd=%h exp err=1 rd=0", e_o, r_o);
    end
    access(1, 1, 0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (r_o !== 32'hDEAD_80EF) begin
      errors++;
      $display("FAIL err_no_write got %h exp dead80ef", r_o);
    end
  endtask

  task automatic test_led_reset();
    access(1, 0, 1, 3'd2, LedAddr, 32'h0000_0001);
    checks++;
    if (e_o !== 1'b0 || led1 !== 1'b1) begin
      errors++;
      $display("FAIL led_set got err=%b led=%b exp err=0 led=1", e_o, led1);
    end
    access(1, 1, 0, 3'd2, LedAddr, 32'h0);
    checks++;
    if (r_o !== 32'h0000_0001) begin
      errors++;
      $display("FAIL led_read got %h exp 00000001", r_o);
    end
    #2;
    reset = 1'b0;
    led_m = 8'h00;
    #1;
    checks++;
    if (led1 !== 1'b0) begin
      errors++;
      $display("FAIL led_async_reset got %b exp 0", led1);
    end
    @(negedge clk);
    reset = 1'b1;
    access(1, 1, 0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (r_o !== 32'hDEAD_80EF) begin
      errors++;
      $display("FAIL ram_kept got %h exp dead80ef", r_o);
    end
  endtask

  task automatic test_random();
    bit rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int pick;
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 7);
      rd = (pick == 0) || (pick >= 4);
      wr = (pick <= 3);
      f3 = 3'($urandom_range(0, 7));
      pick = $urandom_range(0, 9);
      if (pick <= 6)      a = 32'($urandom_range(0, 63));
      else if (pick == 7) a = LedAddr + 32'($urandom_range(0, 1));
      else if (pick == 8) a = 32'h400 + 32'($urandom_range(0, 63));
      else                a = $urandom;
      access(1, rd, wr, f3, a, $urandom);
      checks++;
      if (lat !== 2 || e_o !== exp_e || r_o !== exp_r) begin
        errors++;
        $display("FAIL rand_%0d rd=%b wr=%b f3=%0d a=%h got lat=%0d err=%b rd=%h exp lat=2 err=%b rd=%h",
                 n, rd, wr, f3, a, lat, e_o, r_o, exp_e, exp_r);
      end
      checks++;
      if (rdy_a !== 1'b0 || r_a !== 32'h0) begin
        errors++;
        $display("FAIL rand_after_%0d got ready=%b rd=%h exp ready=0 rd=0", n, rdy_a, r_a);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    access(1, 0, 1, 3'd2, 32'h20, 32'hCAFE_F00D);
    mem = 3'd2; addr = 32'h20; wdata = 32'h1234_5678; wr1 = 1'b1;
    @(posedge clk);
    #1;
    wr1 = 1'b0;
    #2;
    reset = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ready1) seen = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ready1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready got %b exp 0", seen);
    end
    access(1, 1, 0, 3'd2, 32'h20, 32'h0);
    checks++;
    if (r_o !== 32'hCAFE_F00D || lat !== 2) begin
      errors++;
      $display("FAIL abort_ram got rd=%h lat=%0d exp rd=cafef00d lat=2", r_o, lat);
    end
  endtask

  task automatic test_ws0();
    logic [31:0] v;
    v = $urandom;
    access(0, 0, 1, 3'd2, 32'h44, v);
    checks++;
    if (lat !== 1 || e_o !== 1'b0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL ws0_sw got lat=%0d err=%b after=%b exp lat=1 err=0 after=0", lat, e_o, rdy_a);
    end
    access(0, 1, 0, 3'd2, 32'h44, 32'h0);
    checks++;
    if (lat !== 1 || r_o !== v) begin
      errors++;
      $display("FAIL ws0_lw got lat=%0d rd=%h exp lat=1 rd=%h", lat, r_o, v);
    end
    access(0, 0, 1, 3'd0, 32'h45, 32'h0000_00A5);
    access(0, 1, 0, 3'd4, 32'h45, 32'h0);
    checks++;
    if (r_o !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL ws0_lbu got %h exp 000000a5", r_o);
    end
    access(0, 1, 0, 3'd2, 32'h44, 32'h0);
    checks++;
    if (r_o !== {v[31:16], 8'hA5, v[7:0]}) begin
      errors++;
      $display("FAIL ws0_merge got %h exp %h", r_o, {v[31:16], 8'hA5, v[7:0]});
    end
    access(0, 1, 0, 3'd1, 32'h46, 32'h0);
    checks++;
    if (r_o !== {{16{v[31]}}, v[31:16]}) begin
      errors++;
      $display("FAIL ws0_lh got %h exp %h", r_o, {{16{v[31]}}, v[31:16]});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    led_m  = 8'h00;
    test_reset();
    test_fill();
    test_sw_lw();
    test_bytes();
    test_errors();
    test_led_reset();
    test_random();
    test_reset_abort();
    test_ws0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
